play_controller: RTL and testbench

- Move engine for a 2x2 sliding-tile puzzle.
- Holds the working board as four 3-bit cells and loads it from the selected starting board.
- Applies one directional move per rising edge of a direction button and flags when the board reaches the solved arrangement.
- Sits between the top-level game-status FSM (which supplies game_status and origin_bd) and the display/board-select logic (which consumes out_pc and win_flag).

---
 rtl/game_pkg.sv | 23 ++
 rtl/tile_mover.sv | 53 +++++
 rtl/play_controller.sv | 79 +++++++
 tb/tb_play_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the sliding-tile game: status codes, direction bits, board constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } status_e;

  // Bit positions within the act / direction vectors
  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;

  localparam int          CELL_W  = 3;
  localparam int          BOARD_W = 4 * CELL_W;
  localparam logic [11:0] SOLVED  = 12'b000_011_010_001;

endpackage

// File: rtl/tile_mover.sv
// Applies one one-hot directional move to a 2x2 board; illegal moves or a missing blank leave it unchanged.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are.
module tile_mover
  import game_pkg::*;
#(
  parameter int CW = game_pkg::CELL_W
) (
  input  logic [4*CW-1:0] board_i,
  input  logic [3:0]      dir_i,
  output logic [4*CW-1:0] board_o
);

  logic       has_blank;
  logic [1:0] bp;
  logic [1:0] other;
  logic       legal;

  // Locate the blank (lowest index wins), check legality, swap blank with its neighbour
  always_comb begin
    board_o   = board_i;
    has_blank = 1'b0;
    bp        = 2'd0;
    other     = 2'd0;
    legal     = 1'b0;
    // Descending scan so the lowest-index blank is the one that sticks
    for (int i = 3; i >= 0; i--) begin
      if (board_i[i*CW +: CW] == '0) begin
        has_blank = 1'b1;
        bp        = i[1:0];
      end
    end
    // Index layout: bit1 = row (0 top), bit0 = column (0 left)
    if (dir_i[UP]) begin
      legal = ~bp[1];
      other = bp + 2'd2;
    end else if (dir_i[DOWN]) begin
      legal = bp[1];
      other = bp - 2'd2;
    end else if (dir_i[LEFT]) begin
      legal = ~bp[0];
      other = bp + 2'd1;
    end else if (dir_i[RIGHT]) begin
      legal = bp[0];
      other = bp - 2'd1;
    end
    if (has_blank && legal) begin
      board_o[other*CW +: CW] = board_i[bp*CW +: CW];
      board_o[bp*CW +: CW]    = board_i[other*CW +: CW];
    end
  end

endmodule

// File: rtl/play_controller.sv
// Move engine: loads the selected board, applies one move per button press, flags the solved board.
// Latency: board and win_flag update on the same edge that first samples a press.
// Backpressure: none; one move per rising edge of a button, holds ignored.
module play_controller
  import game_pkg::*;
#(
  parameter int          CELL_W = game_pkg::CELL_W,
  parameter logic [11:0] SOLVED = game_pkg::SOLVED
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          game_status,
  input  logic [3:0]          act,
  input  logic [4*CELL_W-1:0] origin_bd,
  output logic [4*CELL_W-1:0] out_pc,
  output logic                win_flag
);

  logic [4*CELL_W-1:0] board_q, board_d;
  logic [4*CELL_W-1:0] moved;
  logic [3:0]          act_q;
  logic [3:0]          press;
  logic [3:0]          dir;
  logic                win_q, win_d;

  assign press = act & ~act_q;

  // Keep only the highest-priority press: up > down > left > right
  always_comb begin
    dir = 4'b0000;
    if (press[UP])         dir[UP]    = 1'b1;
    else if (press[DOWN])  dir[DOWN]  = 1'b1;
    else if (press[LEFT])  dir[LEFT]  = 1'b1;
    else if (press[RIGHT]) dir[RIGHT] = 1'b1;
  end

  tile_mover #(.CW(CELL_W)) u_mover (
    .board_i (board_q),
    .dir_i   (dir),
    .board_o (moved)
  );

  // Next board and win state selected by game phase
  always_comb begin
    board_d = board_q;
    win_d   = win_q;
    case (status_e'(game_status))
      CHOSE_BOARD, GAME_INITIAL: begin
        board_d = origin_bd;
        win_d   = 1'b0;
      end
      GAMING: begin
        if (|press) board_d = moved;
        // Checked on the next board so an already-solved load wins immediately
        win_d = win_q | (board_d == SOLVED);
      end
      default: begin
        // WINNED: board frozen, win_flag holds
      end
    endcase
  end

  // State registers; act_q tracks act in every phase so held buttons never fire on entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      board_q <= '0;
      act_q   <= 4'b0000;
      win_q   <= 1'b0;
    end else begin
      board_q <= board_d;
      act_q   <= act;
      win_q   <= win_d;
    end
  end

  assign out_pc   = board_q;
  assign win_flag = win_q;

endmodule

// File: tb/tb_play_controller.sv
module tb_play_controller;

  localparam logic [1:0] CB = 2'b00;
  localparam logic [1:0] GM = 2'b01;
  localparam logic [1:0] GI = 2'b10;
  localparam logic [1:0] WN = 2'b11;

  localparam logic [11:0] BD_A = 12'b001_011_000_010;
  localparam logic [11:0] BD_U = 12'b000_011_001_010;
  localparam logic [11:0] BD_R = 12'b001_011_010_000;
  localparam logic [11:0] BD_B = 12'b011_000_010_001;
  localparam logic [11:0] BD_S = 12'b000_011_010_001;

  typedef struct {
    logic [1:0]  st;
    logic [3:0]  a;
    logic [11:0] org;
    logic [11:0] eb;
    logic        ew;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [1:0]  game_status;
  logic [3:0]  act;
  logic [11:0] origin_bd;
  logic [11:0] out_pc;
  logic        win_flag;

  logic [11:0] sb_board[$];
  logic        sb_win[$];

  int n_vec  = 0;
  int n_miss = 0;

  play_controller dut (
    .clk         (clk),
    .reset       (reset),
    .game_status (game_status),
    .act         (act),
    .origin_bd   (origin_bd),
    .out_pc      (out_pc),
    .win_flag    (win_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge, record its expectation, sample just after the next rising edge
  task automatic drive(input vec_t v);
    @(negedge clk);
    game_status = v.st;
    act         = v.a;
    origin_bd   = v.org;
    sb_board.push_back(v.eb);
    sb_win.push_back(v.ew);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [11:0] eb;
    logic        ew;
    reset       = 1'b0;
    game_status = CB;
    act         = 4'b0000;
    origin_bd   = BD_A;
    sb_board.push_back(12'd0);
    sb_win.push_back(1'b0);
    repeat (2) @(posedge clk);
    #1;
    eb = sb_board.pop_front();
    ew = sb_win.pop_front();
    n_vec++;
    if (out_pc !== eb) begin n_miss++; $display("FAIL reset out_pc got %b want %b", out_pc, eb); end
    n_vec++;
    if (win_flag !== ew) begin n_miss++; $display("FAIL reset win_flag got %b want %b", win_flag, ew); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_preview;
    vec_t v[$];
    logic [11:0] eb;
    logic        ew;
    v.push_back('{CB, 4'b0000, BD_A, BD_A, 1'b0});
    v.push_back('{CB, 4'b0001, BD_A, BD_A, 1'b0});
    v.push_back('{CB, 4'b0000, BD_A, BD_A, 1'b0});
    v.push_back('{CB, 4'b0000, BD_B, BD_B, 1'b0});
    v.push_back('{CB, 4'b0000, BD_A, BD_A, 1'b0});
    foreach (v[i]) begin
      drive(v[i]);
      eb = sb_board.pop_front();
      ew = sb_win.pop_front();
      n_vec++;
      if (out_pc !== eb) begin n_miss++; $display("FAIL preview[%0d] out_pc got %b want %b", i, out_pc, eb); end
      n_vec++;
      if (win_flag !== ew) begin n_miss++; $display("FAIL preview[%0d] win_flag got %b want %b", i, win_flag, ew); end
    end
  endtask

  task automatic test_moves;
    vec_t v[$];
    logic [11:0] eb;
    logic        ew;
    v.push_back('{GI, 4'b0000, BD_A, BD_A, 1'b0});
    v.push_back('{GM, 4'b0000, BD_B, BD_A, 1'b0});
    v.push_back('{GM, 4'b0001, BD_B, BD_U, 1'b0});
    v.push_back('{GM, 4'b0000, BD_B, BD_U, 1'b0});
    v.push_back('{GM, 4'b0010, BD_B, BD_A, 1'b0});
    v.push_back('{GM, 4'b0000, BD_B, BD_A, 1'b0});
    v.push_back('{GM, 4'b0100, BD_B, BD_A, 1'b0});
    v.push_back('{GM, 4'b0000, BD_B, BD_A, 1'b0});
    v.push_back('{GM, 4'b1000, BD_B, BD_R, 1'b0});
    v.push_back('{GM, 4'b0000, BD_B, BD_R, 1'b0});
    v.push_back('{GM, 4'b0100, BD_B, BD_A, 1'b0});
    v.push_back('{GM, 4'b0000, BD_B, BD_A, 1'b0});
    foreach (v[i]) begin
      drive(v[i]);
      eb = sb_board.pop_front();
      ew = sb_win.pop_front();
      n_vec++;
      if (out_pc !== eb) begin n_miss++; $display("FAIL moves[%0d] out_pc got %b want %b", i, out_pc, eb); end
      n_vec++;
      if (win_flag !== ew) begin n_miss++; $display("FAIL moves[%0d] win_flag got %b want %b", i, win_flag, ew); end
    end
  endtask

  task automatic test_hold;
    vec_t v[$];
    logic [11:0] eb;
    logic        ew;
    v.push_back('{GI, 4'b0000, BD_A, BD_A, 1'b0});
    v.push_back('{GM, 4'b0000, BD_A, BD_A, 1'b0});
    for (int k = 0; k < 5; k++) v.push_back('{GM, 4'b0001, BD_A, BD_U, 1'b0});
    v.push_back('{GM, 4'b0000, BD_A, BD_U, 1'b0});
    // Button held across the GAME_INITIAL -> GAMING transition must not fire
    v.push_back('{GI, 4'b0001, BD_A, BD_A, 1'b0});
    v.push_back('{GM, 4'b0001, BD_A, BD_A, 1'b0});
    v.push_back('{GM, 4'b0000, BD_A, BD_A, 1'b0});
    foreach (v[i]) begin
      drive(v[i]);
      eb = sb_board.pop_front();
      ew = sb_win.pop_front();
      n_vec++;
      if (out_pc !== eb) begin n_miss++; $display("FAIL hold[%0d] out_pc got %b want %b", i, out_pc, eb); end
      n_vec++;
      if (win_flag !== ew) begin n_miss++; $display("FAIL hold[%0d] win_flag got %b want %b", i, win_flag, ew); end
    end
  endtask

  task automatic test_win;
    vec_t v[$];
    logic [11:0] eb;
    logic        ew;
    v.push_back('{GI, 4'b0000, BD_B, BD_B, 1'b0});
    v.push_back('{GM, 4'b0000, BD_B, BD_B, 1'b0});
    v.push_back('{GM, 4'b1000, BD_B, BD_B, 1'b0});
    v.push_back('{GM, 4'b0000, BD_B, BD_B, 1'b0});
    v.push_back('{GM, 4'b0100, BD_B, BD_S, 1'b1});
    v.push_back('{GM, 4'b0000, BD_B, BD_S, 1'b1});
    v.push_back('{WN, 4'b0010, BD_B, BD_S, 1'b1});
    v.push_back('{WN, 4'b0000, BD_B, BD_S, 1'b1});
    v.push_back('{WN, 4'b1000, BD_A, BD_S, 1'b1});
    v.push_back('{GI, 4'b0000, BD_B, BD_B, 1'b0});
    foreach (v[i]) begin
      drive(v[i]);
      eb = sb_board.pop_front();
      ew = sb_win.pop_front();
      n_vec++;
      if (out_pc !== eb) begin n_miss++; $display("FAIL win[%0d] out_pc got %b want %b", i, out_pc, eb); end
      n_vec++;
      if (win_flag !== ew) begin n_miss++; $display("FAIL win[%0d] win_flag got %b want %b", i, win_flag, ew); end
    end
  endtask

  task automatic test_simultaneous;
    vec_t v[$];
    logic [11:0] eb;
    logic        ew;
    v.push_back('{GI, 4'b0000, BD_A, BD_A, 1'b0});
    v.push_back('{GM, 4'b0000, BD_A, BD_A, 1'b0});
    v.push_back('{GM, 4'b1001, BD_A, BD_U, 1'b0});
    v.push_back('{GM, 4'b0000, BD_A, BD_U, 1'b0});
    // down+right from blank at p3: down wins, blank goes to p1
    v.push_back('{GM, 4'b1010, BD_A, BD_A, 1'b0});
    v.push_back('{GM, 4'b0000, BD_A, BD_A, 1'b0});
    foreach (v[i]) begin
      drive(v[i]);
      eb = sb_board.pop_front();
      ew = sb_win.pop_front();
      n_vec++;
      if (out_pc !== eb) begin n_miss++; $display("FAIL simul[%0d] out_pc got %b want %b", i, out_pc, eb); end
      n_vec++;
      if (win_flag !== ew) begin n_miss++; $display("FAIL simul[%0d] win_flag got %b want %b", i, win_flag, ew); end
    end
  endtask

  task automatic test_already_solved;
    vec_t v[$];
    logic [11:0] eb;
    logic        ew;
    v.push_back('{GI, 4'b0000, BD_S, BD_S, 1'b0});
    v.push_back('{GM, 4'b0000, BD_A, BD_S, 1'b1});
    v.push_back('{GM, 4'b0000, BD_A, BD_S, 1'b1});
    foreach (v[i]) begin
      drive(v[i]);
      eb = sb_board.pop_front();
      ew = sb_win.pop_front();
      n_vec++;
      if (out_pc !== eb) begin n_miss++; $display("FAIL solved[%0d] out_pc got %b want %b", i, out_pc, eb); end
      n_vec++;
      if (win_flag !== ew) begin n_miss++; $display("FAIL solved[%0d] win_flag got %b want %b", i, win_flag, ew); end
    end
  endtask

  task automatic test_async_reset;
    logic [11:0] eb;
    logic        ew;
    // Board is solved and win_flag high from the previous scenario; drop reset between edges
    @(negedge clk);
    #1;
    reset = 1'b0;
    sb_board.push_back(12'd0);
    sb_win.push_back(1'b0);
    #1;
    eb = sb_board.pop_front();
    ew = sb_win.pop_front();
    n_vec++;
    if (out_pc !== eb) begin n_miss++; $display("FAIL async_reset out_pc got %b want %b", out_pc, eb); end
    n_vec++;
    if (win_flag !== ew) begin n_miss++; $display("FAIL async_reset win_flag got %b want %b", win_flag, ew); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_preview();
    test_moves();
    test_hold();
    test_win();
    test_simultaneous();
    test_already_solved();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
